// File: rtl/add_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit.
package add_pkg;

   localparam int WORD_LEN = 32;

   function automatic int stages(input int data_len, input int seg_len);
      return data_len / seg_len;
   endfunction

   // Control that rides with every op: carry into the next segment and word-mode flag.
   typedef struct packed {
      logic carry;
      logic word;
   } stage_ctl_t;

endpackage

// File: rtl/add_seg_stage.sv
// One carry-chain segment: adds its SEG_LEN slice of a/bt plus the incoming carry,
// and registers the whole payload for the next segment.
module add_seg_stage
   import add_pkg::*;
#(
   parameter int DATA_LEN = 64,
   parameter int SEG_LEN  = 16,
   parameter int ID_LEN   = 4,
   parameter int IDX      = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                vld_i,
   input  logic                nxt_acc_i,
   input  logic [DATA_LEN-1:0] a_i,
   input  logic [DATA_LEN-1:0] bt_i,
   input  logic [DATA_LEN-1:0] sum_i,
   input  stage_ctl_t          ctl_i,
   input  logic [ID_LEN-1:0]   id_i,
   output logic                vld_o,
   output logic [DATA_LEN-1:0] a_o,
   output logic [DATA_LEN-1:0] bt_o,
   output logic [DATA_LEN-1:0] sum_o,
   output stage_ctl_t          ctl_o,
   output logic [ID_LEN-1:0]   id_o
);

   localparam int LO = IDX * SEG_LEN;

   logic                vld_q;
   logic [DATA_LEN-1:0] a_q;
   logic [DATA_LEN-1:0] bt_q;
   logic [DATA_LEN-1:0] sum_q;
   logic [DATA_LEN-1:0] sum_d;
   stage_ctl_t          ctl_q;
   stage_ctl_t          ctl_d;
   logic [ID_LEN-1:0]   id_q;
   logic [SEG_LEN:0]    seg;
   logic                acc;
   logic                load;

   assign acc  = !vld_q || nxt_acc_i;
   // The entry segment also loads on flush so an op offered alongside flush survives.
   assign load = acc || (flush && (IDX == 0));
   assign seg  = {1'b0, a_i[LO +: SEG_LEN]} + {1'b0, bt_i[LO +: SEG_LEN]}
               + {{SEG_LEN{1'b0}}, ctl_i.carry};

   always_comb begin
      sum_d                = sum_i;
      sum_d[LO +: SEG_LEN] = seg[SEG_LEN-1:0];
      ctl_d                = ctl_i;
      ctl_d.carry          = seg[SEG_LEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
      end else if (flush) begin
         vld_q <= (IDX == 0) ? vld_i : 1'b0;
      end else if (acc) begin
         vld_q <= vld_i;
      end
   end

   always_ff @(posedge clk) begin
      if (load && vld_i) begin
         a_q   <= a_i;
         bt_q  <= bt_i;
         sum_q <= sum_d;
         ctl_q <= ctl_d;
         id_q  <= id_i;
      end
   end

   assign vld_o = vld_q;
   assign a_o   = a_q;
   assign bt_o  = bt_q;
   assign sum_o = sum_q;
   assign ctl_o = ctl_q;
   assign id_o  = id_q;

endmodule

// File: rtl/seg_pipe_add_sub.sv
// Pipelined add/subtract: the carry chain is cut into SEG_LEN segments, one register
// stage each, with valid/ready flow control, flush, tag pass-through and result flags.
module seg_pipe_add_sub
   import add_pkg::*;
#(
   parameter int DATA_LEN = 64,
   parameter int SEG_LEN  = 16,
   parameter int ID_LEN   = 4,
   parameter int WORD_EN  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] in_a,
   input  logic [DATA_LEN-1:0] in_b,
   input  logic                in_sub,
   input  logic                in_word,
   input  logic [ID_LEN-1:0]   in_id,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_sum,
   output logic                out_cout,
   output logic                out_ovf,
   output logic                out_zero,
   output logic [ID_LEN-1:0]   out_id
);

   localparam int STAGES = stages(DATA_LEN, SEG_LEN);
   localparam int MSB    = DATA_LEN - 1;

   if (STAGES < 1 || (DATA_LEN % SEG_LEN) != 0) begin : g_bad_seg
      $error("seg_pipe_add_sub: DATA_LEN must be a non-zero multiple of SEG_LEN");
   end
   if (WORD_EN != 0 && DATA_LEN != 64) begin : g_bad_word
      $error("seg_pipe_add_sub: WORD_EN requires DATA_LEN == 64");
   end

   // Index 0 is the issue side; index k+1 is the register output of segment k.
   logic                vld_s [STAGES+1];
   logic                acc_s [STAGES+1];
   logic [DATA_LEN-1:0] a_s   [STAGES+1];
   logic [DATA_LEN-1:0] bt_s  [STAGES+1];
   logic [DATA_LEN-1:0] sum_s [STAGES+1];
   stage_ctl_t          ctl_s [STAGES+1];
   logic [ID_LEN-1:0]   id_s  [STAGES+1];

   assign vld_s[0] = in_valid;
   assign a_s[0]   = in_a;
   assign bt_s[0]  = in_b ^ {DATA_LEN{in_sub}};
   assign sum_s[0] = '0;
   assign ctl_s[0] = '{carry: in_sub, word: (WORD_EN != 0) && in_word};
   assign id_s[0]  = in_id;

   always_comb begin
      acc_s[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc_s[k] = !vld_s[k+1] || acc_s[k+1];
      end
   end

   assign in_ready = acc_s[0] || flush;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_seg_stage #(
         .DATA_LEN (DATA_LEN),
         .SEG_LEN  (SEG_LEN),
         .ID_LEN   (ID_LEN),
         .IDX      (k)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .vld_i     (vld_s[k]),
         .nxt_acc_i (acc_s[k+1]),
         .a_i       (a_s[k]),
         .bt_i      (bt_s[k]),
         .sum_i     (sum_s[k]),
         .ctl_i     (ctl_s[k]),
         .id_i      (id_s[k]),
         .vld_o     (vld_s[k+1]),
         .a_o       (a_s[k+1]),
         .bt_o      (bt_s[k+1]),
         .sum_o     (sum_s[k+1]),
         .ctl_o     (ctl_s[k+1]),
         .id_o      (id_s[k+1])
      );
   end

   logic [DATA_LEN-1:0] s_fin;
   logic [DATA_LEN-1:0] a_fin;
   logic [DATA_LEN-1:0] bt_fin;
   stage_ctl_t          ctl_fin;
   logic                ovf_full;
   logic                unused_ok;

   assign s_fin    = sum_s[STAGES];
   assign a_fin    = a_s[STAGES];
   assign bt_fin   = bt_s[STAGES];
   assign ctl_fin  = ctl_s[STAGES];
   assign ovf_full = (a_fin[MSB] == bt_fin[MSB]) && (s_fin[MSB] != a_fin[MSB]);

   if (WORD_EN != 0) begin : g_word
      logic [DATA_LEN-1:0] res_w;
      logic                cout_w;
      logic                ovf_w;
      // Carry out of bit 31 is recovered from bit 32 of the full-width add.
      assign res_w  = {{(DATA_LEN-WORD_LEN){s_fin[WORD_LEN-1]}}, s_fin[WORD_LEN-1:0]};
      assign cout_w = s_fin[WORD_LEN] ^ a_fin[WORD_LEN] ^ bt_fin[WORD_LEN];
      assign ovf_w  = (a_fin[WORD_LEN-1] == bt_fin[WORD_LEN-1])
                   && (s_fin[WORD_LEN-1] != a_fin[WORD_LEN-1]);
      assign out_sum  = ctl_fin.word ? res_w  : s_fin;
      assign out_cout = ctl_fin.word ? cout_w : ctl_fin.carry;
      assign out_ovf  = ctl_fin.word ? ovf_w  : ovf_full;
   end else begin : g_full
      assign out_sum  = s_fin;
      assign out_cout = ctl_fin.carry;
      assign out_ovf  = ovf_full;
   end

   assign out_valid = vld_s[STAGES];
   assign out_id    = id_s[STAGES];
   assign out_zero  = (out_sum == '0);
   assign unused_ok = ^{a_fin, bt_fin, ctl_fin};

endmodule

// File: tb/tb_seg_pipe_add_sub.sv
// Bench for seg_pipe_add_sub (64-bit, 16-bit segments): directed vectors plus a
// queue-based reference model checked on every output cycle.
`timescale 1ns/1ps
module tb_seg_pipe_add_sub;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_sub, in_word;
   logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
   logic [63:0] in_a, in_b, out_sum;
   logic [3:0]  in_id, out_id;

   always #5 clk = ~clk;

   seg_pipe_add_sub #(
      .DATA_LEN (64),
      .SEG_LEN  (16),
      .ID_LEN   (4),
      .WORD_EN  (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_word   (in_word),
      .in_id     (in_id),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_id    (out_id)
   );

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic [3:0]  id;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          n_deliv = 0;
   bit          saw_ir_low = 0;
   bit          prev_stall = 0;
   logic [70:0] prev_out;

   localparam logic signed [65:0] MAX64 = 66'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [65:0] MIN64 = -66'sh0_8000_0000_0000_0000;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results from plain unsigned/signed arithmetic on a and b.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic word, input logic [3:0] id);
      exp_t             e;
      logic [64:0]      u;
      logic [32:0]      uw;
      logic signed [65:0] sr;
      longint           sx, sy, rs;
      e.id = id;
      if (word) begin
         uw = sub ? ({1'b0, a[31:0]} - {1'b0, b[31:0]}) : ({1'b0, a[31:0]} + {1'b0, b[31:0]});
         sx = longint'($signed(a[31:0]));
         sy = longint'($signed(b[31:0]));
         rs = sub ? sx - sy : sx + sy;
         e.sum  = {{32{uw[31]}}, uw[31:0]};
         e.cout = sub ? (a[31:0] >= b[31:0]) : uw[32];
         e.ovf  = (rs > 64'sh7FFF_FFFF) || (rs < -64'sh8000_0000);
      end else begin
         u  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
         sr = sub ? ($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}))
                  : ($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
         e.sum  = u[63:0];
         e.cout = sub ? (a >= b) : u[64];
         e.ovf  = (sr > MAX64) || (sr < MIN64);
      end
      e.zero = (e.sum == 64'd0);
      return e;
   endfunction

   // Compare process: every cycle with rst low.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            q.delete();
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 72'(out_valid), 72'(1));
               check("hold_data", 72'({out_sum, out_cout, out_ovf, out_zero, out_id}), 72'(prev_out));
            end
            if (out_valid) begin
               if (q.size() == 0) begin
                  check("spurious_out_valid", 72'(out_valid), 72'(0));
               end else begin
                  e = q[0];
                  check("sum", 72'(out_sum), 72'(e.sum));
                  check("flags_id", 72'({out_cout, out_ovf, out_zero, out_id}),
                        72'({e.cout, e.ovf, e.zero, e.id}));
                  if (out_ready) void'(q.pop_front());
               end
               if (out_ready) n_deliv++;
            end
            if (in_valid && !in_ready) saw_ir_low = 1;
            prev_stall = out_valid && !out_ready && !flush;
            prev_out   = {out_sum, out_cout, out_ovf, out_zero, out_id};
            if (flush) q.delete();
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_sub, in_word, in_id));
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that took the op.
   task automatic put(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic word, input logic [3:0] id);
      bit ok = 0;
      in_valid = 1; in_a = a; in_b = b; in_sub = sub; in_word = word; in_id = id;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) check("accept_timeout", 72'(in_ready), 72'(1));
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic directed(input string nm, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic word, input logic [3:0] id,
                           input logic [63:0] esum, input logic [2:0] eflags);
      int lat;
      put(a, b, sub, word, id);
      wait_out(lat);
      check({nm, "_latency"}, 72'(lat), 72'(LAT));
      check({nm, "_sum"}, 72'(out_sum), 72'(esum));
      check({nm, "_flags"}, 72'({out_cout, out_ovf, out_zero, out_id}), 72'({eflags, id}));
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   lat, base, cnt;
      rst = 1; flush = 0; in_valid = 0; in_a = '0; in_b = '0;
      in_sub = 0; in_word = 0; in_id = '0; out_ready = 1;

      // Pin the reference model to hand-computed results ({sum, cout, ovf, zero}).
      e = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd0);
      check("model_allones", 72'({e.sum, e.cout, e.ovf, e.zero}), 72'({64'h0, 3'b101}));
      e = model(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 4'd0);
      check("model_minsub", 72'({e.sum, e.cout, e.ovf, e.zero}), 72'({64'h7FFF_FFFF_FFFF_FFFF, 3'b110}));
      e = model(64'd3, 64'd5, 1'b1, 1'b0, 4'd0);
      check("model_borrow", 72'({e.sum, e.cout, e.ovf, e.zero}), 72'({64'hFFFF_FFFF_FFFF_FFFE, 3'b000}));
      e = model(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b1, 4'd0);
      check("model_word_ovf", 72'({e.sum, e.cout, e.ovf, e.zero}), 72'({64'hFFFF_FFFF_8000_0000, 3'b010}));
      e = model(64'h1_0000_0005, 64'd5, 1'b1, 1'b1, 4'd0);
      check("model_word_zero", 72'({e.sum, e.cout, e.ovf, e.zero}), 72'({64'h0, 3'b101}));

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("reset_out_valid", 72'(out_valid), 72'(0));
      check("reset_in_ready", 72'(in_ready), 72'(1));
      @(posedge clk); #1;

      directed("add_allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd1, 64'h0, 3'b101);
      directed("sub_min", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110);
      directed("sub_borrow", 64'd3, 64'd5, 1'b1, 1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000);
      directed("word_add", 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b1, 4'd4, 64'hFFFF_FFFF_8000_0000, 3'b010);
      directed("word_sub", 64'h1_0000_0005, 64'd5, 1'b1, 1'b1, 4'd5, 64'h0, 3'b101);

      // Back-to-back stream with a three-cycle consumer stall.
      base = n_deliv;
      saw_ir_low = 0;
      fork
         for (int i = 0; i < 8; i++)
            put(64'hF000_0000_0000_0000 + 64'(i) * 64'h1357_9BDF_0246_8ACE,
                64'h0FFF_FFFF_FFFF_FFFF - 64'(i) * 64'h0101_0101_0101_0101,
                i[0], (i == 5), 4'(i));
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      for (int t = 0; t < 40 && (n_deliv - base) < 8; t++) @(negedge clk);
      check("stream_delivered", 72'(n_deliv - base), 72'(8));
      check("stream_in_ready_dropped", 72'(saw_ir_low), 72'(1));
      @(posedge clk); #1;

      // Flush with three ops in flight and a new op on the same cycle.
      put(64'd10, 64'd20, 1'b0, 1'b0, 4'd1);
      put(64'd11, 64'd21, 1'b0, 1'b0, 4'd2);
      put(64'd12, 64'd22, 1'b0, 1'b0, 4'd3);
      base = n_deliv;
      flush = 1; in_valid = 1; in_a = 64'd100; in_b = 64'd1; in_sub = 1; in_word = 0; in_id = 4'd9;
      @(negedge clk);
      check("flush_in_ready", 72'(in_ready), 72'(1));
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      wait_out(lat);
      check("flush_latency", 72'(lat), 72'(LAT));
      check("flush_survivor", 72'({out_id, out_sum}), 72'({4'd9, 64'd99}));
      repeat (8) @(negedge clk);
      check("flush_delivered", 72'(n_deliv - base), 72'(1));
      @(posedge clk); #1;

      // Reset with four ops in flight.
      out_ready = 0;
      for (int i = 0; i < 4; i++) put(64'(i) * 64'd7, 64'd3, 1'b0, 1'b0, 4'(4 + i));
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      check("rst_out_valid", 72'(out_valid), 72'(0));
      check("rst_in_ready", 72'(in_ready), 72'(1));
      out_ready = 1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("rst_no_stale", 72'(cnt), 72'(0));
      check("model_queue_empty", 72'(q.size()), 72'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
